axis2fifo_pack: RTL and testbench
=================================

Name: axis2fifo_pack

Overview:
AXI4-Stream slave that accepts 32-bit pixels and packs 4 beats into one 128-bit word. It pushes each word into the forward (write) side of the frame-buffer FIFO. It is the ingress counterpart of the existing FIFO-to-AXIS unpacker, so word layout must match: pixel 0 sits in [127:96] and pixel 3 in [31:0]. It aligns to frame start via S_AXIS_USER and checks line length against PIXELS_HORIZONTAL.

Parameters:
FDW, 128, FIFO word width; must equal 4*AXIS_DATA_WIDTH
AXIS_DATA_WIDTH, 32, pixel/beat width
PIXELS_HORIZONTAL, 1280, pixels per line; multiple of 4, at least 4
PIXELS_VERTICAL, 1024, lines per frame

Ports:
S_AXIS_ACLK  in  1  sole clock
S_AXIS_ARESETN  in  1  reset; one clock; reset is synchronous and active-low
S_AXIS_TVALID  in  1  beat valid
S_AXIS_TREADY  out  1  beat accepted when TVALID&&TREADY
S_AXIS_TDATA  in  AXIS_DATA_WIDTH  pixel
S_AXIS_TSTRB  in  AXIS_DATA_WIDTH/8  ignored (all bytes treated valid)
S_AXIS_TLAST  in  1  last pixel of line
S_AXIS_USER  in  1  first pixel of frame
fwr_vld  out  1  fwr_dout valid; write occurs when fwr_vld&&fwr_rdy
fwr_rdy  in  1  FIFO can accept (FIFO drives it as !full)
fwr_dout  out  FDW  packed word
fwr_sof  out  1  word holds pixel 0 of a frame; qualified by fwr_vld
fwr_eol  out  1  word holds last pixel of a line; qualified by fwr_vld
frame_cnt  out  11  frames fully received; saturates at 2047
err_len  out  1  sticky line-length error
err_clr  in  1  clears err_len (single-cycle pulse)

Behaviour:
- Reset values: TREADY=0, fwr_vld=0, fwr_dout=0, fwr_sof=0, fwr_eol=0, frame_cnt=0, err_len=0. State=WAIT_SOF, lane=0, pix_cnt=0, line_cnt=0.
- TREADY in WAIT_SOF is 1; beats are dropped until a beat with USER=1 is accepted.
- WAIT_SOF -> ACTIVE when a USER=1 beat is accepted. That beat is lane 0 of the frame; its word carries fwr_sof=1.
- ACTIVE: each accepted beat is written into lane (0..3) of the accumulator. lane++ and pix_cnt++.
- Word completes on lane==3 or on TLAST. The complete word is copied to the output register: fwr_vld=1 on the next cycle, so latency from the accepting edge of lane 3 to fwr_vld is 1 cycle.
- Output register holds word, sof and eol stable until fwr_vld&&fwr_rdy. fwr_vld drops after the write unless a new word loads in the same cycle.
- TREADY in ACTIVE = !(completing beat) || !fwr_vld || fwr_rdy. Lanes 0-2 are never stalled. A completing beat stalls only while the output register is occupied and not draining. Back-to-back words at full rate when fwr_rdy=1.
- TLAST with pix_cnt==PIXELS_HORIZONTAL-1: fwr_eol=1, pix_cnt=0, line_cnt++.
- Line 0 must start with USER. USER=1 seen in ACTIVE at pix_cnt!=0 or line_cnt!=0:
  - set err_len;
  - flush the current partial word, with unused lanes zero and eol=1;
  - restart the frame with this beat as the new sof.
- TLAST early (pix_cnt<H-1): set err_len. Flush the partial word with unused lanes zero and fwr_eol=1. pix_cnt=0, line_cnt++.
- pix_cnt reaches H-1 without TLAST: set err_len, treat as end of line anyway (eol=1, pix_cnt=0).
- Last line ends (line_cnt==PIXELS_VERTICAL-1 at eol): frame_cnt++ (saturating), line_cnt=0, state=WAIT_SOF.
- If a flush and the pending output register collide, the flush obeys the same TREADY stall rule.
- err_clr and a new error in the same cycle: set wins.
- Reset mid-frame: partial accumulator and pending word are discarded. No write occurs in the reset cycle.
- fwr_dout lanes are mapped MSB-first: lane k occupies [FDW-1-32k : FDW-32-32k].

Decomposition:
- Shared package: state encoding (WAIT_SOF, ACTIVE), lane-index width, clogb2 function, lane-to-bit-offset constant.
- Natural sub-module: axis_word_pack_reg, holding the output register plus valid/ready handshake. The top level keeps framing, counters and errors.

Test Plan:
- H=8,V=2, continuous TVALID, fwr_rdy=1; USER on pixel 0, pixels 0x0..0xF -> 4 writes: 0x00000000_00000001_00000002_00000003 (sof=1), ...4..7 (eol=1), ...8..B, ...C..F (eol=1); frame_cnt=1.
- 3 beats without USER, then frame -> first 3 beats dropped, no write before the USER beat, TREADY=1 throughout.
- fwr_rdy=0 for 10 cycles after the first word -> TREADY drops on lane 3 of the second word; no data lost; words leave in order once fwr_rdy=1.
- TLAST on pixel 5 of a line (H=8) -> second word = pix4,pix5,0,0 with eol=1; err_len=1 until err_clr pulse.
- USER mid-line at pixel 2 -> partial word flushed, zero-padded; err_len=1; new word has sof=1; frame_cnt is not incremented.
- Reset asserted while fwr_vld=1 -> next cycle fwr_vld=0, TREADY=0, frame_cnt=0; the following frame packs correctly.

Source files
------------

// File: rtl/axis2fifo_pack_pkg.sv
// Shared definitions for the AXI4-Stream to FIFO pixel packer.
package axis2fifo_pack_pkg;

   // Framing state: hunting for frame start, or packing an aligned frame
   typedef enum logic {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } state_t;

   // Pixels per FIFO word
   localparam int LANES = 4;

   // Ceiling log2, used to size counters from parameters
   function automatic int clogb2(input int value);
      int r = 0;
      while ((1 << r) < value) r = r + 1;
      return r;
   endfunction

   localparam int LANE_W = clogb2(LANES);

   // Lane k is placed MSB-first: lane 0 in the top slice of the word
   function automatic int lane_lsb(input int fdw, input int dw, input int k);
      return fdw - dw * (k + 1);
   endfunction

endpackage

// File: rtl/axis_word_pack_reg.sv
// Output holding register for one packed word with valid/ready handshake.
module axis_word_pack_reg
   import axis2fifo_pack_pkg::*;
#(
   parameter int FDW = 128
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [FDW-1:0] din,
   input  logic           sof_in,
   input  logic           eol_in,
   input  logic           rdy,
   output logic           can_load,
   output logic           vld,
   output logic [FDW-1:0] dout,
   output logic           sof,
   output logic           eol
);

   logic           vld_reg;
   logic [FDW-1:0] dout_reg;
   logic           sof_reg;
   logic           eol_reg;

   // Capture a completed word; hold it until the FIFO takes it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_reg  <= 1'b0;
         dout_reg <= '0;
         sof_reg  <= 1'b0;
         eol_reg  <= 1'b0;
      end else if (load) begin
         vld_reg  <= 1'b1;
         dout_reg <= din;
         sof_reg  <= sof_in;
         eol_reg  <= eol_in;
      end else if (rdy) begin
         vld_reg  <= 1'b0;
      end
   end

   // Register is free when empty or draining this cycle
   assign can_load = !vld_reg || rdy;
   // Valid is masked during reset so the FIFO never writes in the reset cycle
   assign vld      = vld_reg && rst_n;
   assign dout     = dout_reg;
   assign sof      = sof_reg;
   assign eol      = eol_reg;

endmodule

// File: rtl/axis2fifo_pack.sv
// AXI4-Stream slave packing four 32-bit pixels into one FIFO word,
// with frame alignment on USER and line-length checking.
module axis2fifo_pack
   import axis2fifo_pack_pkg::*;
#(
   parameter int FDW               = 128,
   parameter int AXIS_DATA_WIDTH   = 32,
   parameter int PIXELS_HORIZONTAL = 1280,
   parameter int PIXELS_VERTICAL   = 1024
) (
   input  logic                         S_AXIS_ACLK,
   input  logic                         S_AXIS_ARESETN,
   input  logic                         S_AXIS_TVALID,
   output logic                         S_AXIS_TREADY,
   input  logic [AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
   input  logic [AXIS_DATA_WIDTH/8-1:0] S_AXIS_TSTRB,
   input  logic                         S_AXIS_TLAST,
   input  logic                         S_AXIS_USER,
   output logic                         fwr_vld,
   input  logic                         fwr_rdy,
   output logic [FDW-1:0]               fwr_dout,
   output logic                         fwr_sof,
   output logic                         fwr_eol,
   output logic [10:0]                  frame_cnt,
   output logic                         err_len,
   input  logic                         err_clr
);

   localparam int DW     = AXIS_DATA_WIDTH;
   localparam int PIX_W  = clogb2(PIXELS_HORIZONTAL);
   localparam int LINE_W = (clogb2(PIXELS_VERTICAL) < 1) ? 1 : clogb2(PIXELS_VERTICAL);
   localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(PIXELS_HORIZONTAL - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(PIXELS_VERTICAL - 1);
   localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(LANES - 1);

   state_t              state_reg;
   logic [LANE_W-1:0]   lane_reg;
   logic [PIX_W-1:0]    pix_cnt_reg;
   logic [LINE_W-1:0]   line_cnt_reg;
   logic                sof_pend_reg;
   logic                running_reg;
   logic [10:0]         frame_cnt_reg;
   logic                err_len_reg;
   logic [DW-1:0]       acc_reg [LANES-1];

   logic                in_active, restart, take, flush;
   logic [LANE_W-1:0]   cur_lane;
   logic [PIX_W-1:0]    cur_pix;
   logic [LINE_W-1:0]   cur_line;
   logic                at_h_end, last_eff, eol_beat, need_load;
   logic                tready, fire, load, err_set;
   logic                word_sof, word_eol, out_can_load;
   logic [DW-1:0]       lane_word [LANES];
   logic [FDW-1:0]      word_next;
   logic                unused_tstrb;

   // Byte strobes carry no meaning here; every byte is treated as valid
   assign unused_tstrb = ^S_AXIS_TSTRB;

   // Classify the beat on the bus and decide whether it needs the output register
   always_comb begin
      in_active = (state_reg == ACTIVE);
      // USER outside the first pixel of line 0 restarts the frame on this beat
      restart   = S_AXIS_USER && (!in_active || pix_cnt_reg != '0 || line_cnt_reg != '0);
      take      = in_active || S_AXIS_USER;
      // A restart with pixels already accumulated pushes them out first;
      // a TLAST on that same beat is ignored since the register takes only one word
      flush     = in_active && restart && (lane_reg != '0);
      cur_lane  = restart ? '0 : lane_reg;
      cur_pix   = restart ? '0 : pix_cnt_reg;
      cur_line  = restart ? '0 : line_cnt_reg;
      at_h_end  = (cur_pix == PIX_LAST);
      last_eff  = S_AXIS_TLAST && !flush;
      eol_beat  = last_eff || at_h_end;
      need_load = take && (flush || cur_lane == LANE_LAST || eol_beat);
      tready    = running_reg && S_AXIS_ARESETN && (!need_load || out_can_load);
      fire      = S_AXIS_TVALID && tready && take;
      load      = fire && need_load;
      err_set   = fire && ((in_active && restart) ||
                           (last_eff && !at_h_end) ||
                           (at_h_end && !S_AXIS_TLAST));
      word_sof  = flush ? sof_pend_reg : (restart || sof_pend_reg);
      word_eol  = flush || eol_beat;
   end

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         localparam int LSB = lane_lsb(FDW, DW, gi);
         if (gi < LANES - 1) begin : g_stored
            // Word lane: earlier lanes from the accumulator, current lane from the bus, rest zero
            assign lane_word[gi] = flush ? ((LANE_W'(gi) < lane_reg) ? acc_reg[gi] : '0)
                                 : (LANE_W'(gi) < cur_lane)  ? acc_reg[gi]
                                 : (LANE_W'(gi) == cur_lane) ? S_AXIS_TDATA : '0;

            // Accumulate the pixel arriving for this lane
            always_ff @(posedge S_AXIS_ACLK) begin
               if (!S_AXIS_ARESETN)
                  acc_reg[gi] <= '0;
               else if (fire && cur_lane == LANE_W'(gi))
                  acc_reg[gi] <= S_AXIS_TDATA;
            end
         end else begin : g_last
            // The last lane always completes a word, so it comes straight from the bus
            assign lane_word[gi] = (!flush && cur_lane == LANE_W'(gi)) ? S_AXIS_TDATA : '0;
         end
         assign word_next[LSB +: DW] = lane_word[gi];
      end
   endgenerate

   // Framing FSM with pixel/line/frame counters and sticky length error
   always_ff @(posedge S_AXIS_ACLK) begin
      if (!S_AXIS_ARESETN) begin
         state_reg     <= WAIT_SOF;
         lane_reg      <= '0;
         pix_cnt_reg   <= '0;
         line_cnt_reg  <= '0;
         sof_pend_reg  <= 1'b0;
         running_reg   <= 1'b0;
         frame_cnt_reg <= '0;
         err_len_reg   <= 1'b0;
      end else begin
         running_reg <= 1'b1;
         if (err_set)
            err_len_reg <= 1'b1;
         else if (err_clr)
            err_len_reg <= 1'b0;
         if (fire) begin
            sof_pend_reg <= (need_load && !flush) ? 1'b0 : (restart || sof_pend_reg);
            if (eol_beat) begin
               pix_cnt_reg <= '0;
               lane_reg    <= '0;
               if (cur_line == LINE_LAST) begin
                  line_cnt_reg <= '0;
                  state_reg    <= WAIT_SOF;
                  if (frame_cnt_reg != 11'h7FF)
                     frame_cnt_reg <= frame_cnt_reg + 11'd1;
               end else begin
                  line_cnt_reg <= cur_line + LINE_W'(1);
                  state_reg    <= ACTIVE;
               end
            end else begin
               pix_cnt_reg  <= cur_pix + PIX_W'(1);
               lane_reg     <= (cur_lane == LANE_LAST) ? '0 : cur_lane + LANE_W'(1);
               line_cnt_reg <= cur_line;
               state_reg    <= ACTIVE;
            end
         end
      end
   end

   axis_word_pack_reg #(
      .FDW (FDW)
   ) u_out_reg (
      .clk      (S_AXIS_ACLK),
      .rst_n    (S_AXIS_ARESETN),
      .load     (load),
      .din      (word_next),
      .sof_in   (word_sof),
      .eol_in   (word_eol),
      .rdy      (fwr_rdy),
      .can_load (out_can_load),
      .vld      (fwr_vld),
      .dout     (fwr_dout),
      .sof      (fwr_sof),
      .eol      (fwr_eol)
   );

   assign S_AXIS_TREADY = tready;
   assign frame_cnt     = frame_cnt_reg;
   assign err_len       = err_len_reg;

endmodule

// File: tb/tb_axis2fifo_pack.sv
// Self-checking bench for axis2fifo_pack with a pixel-level reference model.
module tb_axis2fifo_pack;

   localparam int H = 8;
   localparam int V = 2;

   logic         clk;
   logic         S_AXIS_ARESETN;
   logic         S_AXIS_TVALID;
   logic         S_AXIS_TREADY;
   logic [31:0]  S_AXIS_TDATA;
   logic [3:0]   S_AXIS_TSTRB;
   logic         S_AXIS_TLAST;
   logic         S_AXIS_USER;
   logic         fwr_vld;
   logic         fwr_rdy;
   logic [127:0] fwr_dout;
   logic         fwr_sof;
   logic         fwr_eol;
   logic [10:0]  frame_cnt;
   logic         err_len;
   logic         err_clr;

   axis2fifo_pack #(
      .FDW               (128),
      .AXIS_DATA_WIDTH   (32),
      .PIXELS_HORIZONTAL (H),
      .PIXELS_VERTICAL   (V)
   ) dut (
      .S_AXIS_ACLK    (clk),
      .S_AXIS_ARESETN (S_AXIS_ARESETN),
      .S_AXIS_TVALID  (S_AXIS_TVALID),
      .S_AXIS_TREADY  (S_AXIS_TREADY),
      .S_AXIS_TDATA   (S_AXIS_TDATA),
      .S_AXIS_TSTRB   (S_AXIS_TSTRB),
      .S_AXIS_TLAST   (S_AXIS_TLAST),
      .S_AXIS_USER    (S_AXIS_USER),
      .fwr_vld        (fwr_vld),
      .fwr_rdy        (fwr_rdy),
      .fwr_dout       (fwr_dout),
      .fwr_sof        (fwr_sof),
      .fwr_eol        (fwr_eol),
      .frame_cnt      (frame_cnt),
      .err_len        (err_len),
      .err_clr        (err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [127:0] d;
      logic         sof;
      logic         eol;
   } word_t;

   int    tests = 0;
   int    fails = 0;
   word_t exp_q [$];
   word_t wlog  [$];

   // Reference model state: pixels of the word being built, position in frame
   logic [31:0] m_word [$];
   bit          m_active = 0;
   bit          m_sof    = 0;
   int          m_pix    = 0;
   int          m_line   = 0;
   int          m_frames = 0;
   bit          m_err    = 0;
   bit          e_set    = 0;
   bit          stall_seen = 0;

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   task automatic chk_log(input int idx, input logic [127:0] d, input logic sof, input logic eol);
      if (idx >= wlog.size()) begin
         tests++;
         fails++;
         $display("FAIL log_word_%0d: got %0d writes, required more than %0d", idx, wlog.size(), idx);
      end else begin
         chk($sformatf("log_data_%0d", idx), wlog[idx].d, d);
         chk($sformatf("log_sof_%0d", idx), 128'(wlog[idx].sof), 128'(sof));
         chk($sformatf("log_eol_%0d", idx), 128'(wlog[idx].eol), 128'(eol));
      end
   endtask

   // Pack the pending pixels MSB-first, zero-fill, queue as an expected write
   task automatic m_emit(input bit eol);
      word_t w;
      w.d = '0;
      for (int i = 0; i < m_word.size(); i++)
         w.d[127 - 32*i -: 32] = m_word[i];
      w.sof = m_sof;
      w.eol = eol;
      exp_q.push_back(w);
      m_word.delete();
      m_sof = 0;
   endtask

   task automatic m_beat(input logic [31:0] d, input logic u, input logic l);
      bit flushed = 0;
      bit last;
      bit eol;
      if (!m_active) begin
         if (!u) return;
         m_active = 1;
         m_pix = 0;
         m_line = 0;
         m_word.delete();
         m_sof = 1;
      end else if (u && (m_pix != 0 || m_line != 0)) begin
         e_set = 1;
         if (m_word.size() > 0) begin
            m_emit(1);
            flushed = 1;
         end
         m_pix = 0;
         m_line = 0;
         m_sof = 1;
      end
      m_word.push_back(d);
      last = l && !flushed;
      eol  = last || (m_pix == H - 1);
      if ((last && m_pix != H - 1) || (m_pix == H - 1 && !l)) e_set = 1;
      if (eol || m_word.size() == 4) m_emit(eol);
      if (eol) begin
         m_pix = 0;
         if (m_line == V - 1) begin
            m_line = 0;
            m_active = 0;
            if (m_frames < 2047) m_frames++;
         end else begin
            m_line++;
         end
      end else begin
         m_pix++;
      end
   endtask

   // Per-cycle compare against the model, then advance the model with this cycle's handshakes
   always @(negedge clk) begin
      word_t e;
      word_t got_w;
      chk("frame_cnt", 128'(frame_cnt), 128'(m_frames));
      chk("err_len", 128'(err_len), 128'(m_err));
      e_set = 0;
      if (S_AXIS_ARESETN) begin
         if (fwr_vld && fwr_rdy) begin
            got_w.d = fwr_dout;
            got_w.sof = fwr_sof;
            got_w.eol = fwr_eol;
            wlog.push_back(got_w);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: got %0h, required no write", fwr_dout);
            end else begin
               e = exp_q.pop_front();
               chk("wr_data", fwr_dout, e.d);
               chk("wr_sof", 128'(fwr_sof), 128'(e.sof));
               chk("wr_eol", 128'(fwr_eol), 128'(e.eol));
            end
         end
         if (S_AXIS_TVALID && !S_AXIS_TREADY) stall_seen = 1;
         if (S_AXIS_TVALID && S_AXIS_TREADY) m_beat(S_AXIS_TDATA, S_AXIS_USER, S_AXIS_TLAST);
         if (e_set) m_err = 1;
         else if (err_clr) m_err = 0;
      end else begin
         exp_q.delete();
         m_word.delete();
         m_active = 0;
         m_sof = 0;
         m_pix = 0;
         m_line = 0;
         m_frames = 0;
         m_err = 0;
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic u, input logic l, output int stalls);
      bit done = 0;
      bit acc;
      S_AXIS_TDATA  = d;
      S_AXIS_USER   = u;
      S_AXIS_TLAST  = l;
      S_AXIS_TVALID = 1'b1;
      stalls = 0;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         acc = S_AXIS_TREADY;
         @(posedge clk);
         #1;
         if (acc) done = 1;
         else stalls++;
      end
      S_AXIS_TVALID = 1'b0;
      S_AXIS_USER   = 1'b0;
      S_AXIS_TLAST  = 1'b0;
      tests++;
      if (!done) begin
         fails++;
         $display("FAIL beat_timeout: got no accept, required accept of %0h", d);
      end
   endtask

   task automatic send_frame(input int base);
      int st;
      for (int l = 0; l < V; l++)
         for (int p = 0; p < H; p++)
            send_beat(32'(base + l*H + p), (l == 0 && p == 0), (p == H - 1), st);
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      int st;
      bit seen;
      S_AXIS_ARESETN = 1'b0;
      S_AXIS_TVALID  = 1'b0;
      S_AXIS_TDATA   = '0;
      S_AXIS_TSTRB   = 4'hF;
      S_AXIS_TLAST   = 1'b0;
      S_AXIS_USER    = 1'b0;
      fwr_rdy        = 1'b1;
      err_clr        = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      S_AXIS_ARESETN = 1'b1;

      // Basic frame, pixels 0x0..0xF
      send_frame(0);
      drain();
      chk_log(0, 128'h00000000_00000001_00000002_00000003, 1'b1, 1'b0);
      chk_log(1, 128'h00000004_00000005_00000006_00000007, 1'b0, 1'b1);
      chk_log(2, 128'h00000008_00000009_0000000A_0000000B, 1'b0, 1'b0);
      chk_log(3, 128'h0000000C_0000000D_0000000E_0000000F, 1'b0, 1'b1);
      chk("frame_cnt_t1", 128'(frame_cnt), 128'd1);

      // Beats before USER are accepted and dropped
      for (int i = 0; i < 3; i++) begin
         send_beat(32'hDEAD0000 + 32'(i), 1'b0, 1'b0, st);
         chk("drop_tready_stalls", 128'(st), 128'd0);
      end
      drain();
      chk("drop_no_write", 128'(wlog.size()), 128'd4);
      send_frame(32'h100);
      drain();
      chk_log(4, 128'h00000100_00000101_00000102_00000103, 1'b1, 1'b0);
      chk("frame_cnt_t2", 128'(frame_cnt), 128'd2);

      // Backpressure: FIFO full for 10 cycles after the first word
      fwr_rdy = 1'b0;
      stall_seen = 0;
      fork
         send_frame(32'h200);
         begin
            seen = 0;
            for (int n = 0; n < 60 && !seen; n++) begin
               @(negedge clk);
               if (fwr_vld) seen = 1;
            end
            tests++;
            if (!seen) begin
               fails++;
               $display("FAIL bp_first_word: got no fwr_vld, required fwr_vld");
            end
            repeat (10) @(posedge clk);
            #1;
            fwr_rdy = 1'b1;
         end
      join
      drain();
      chk("bp_stall_seen", 128'(stall_seen), 128'd1);
      chk_log(8, 128'h00000200_00000201_00000202_00000203, 1'b1, 1'b0);
      chk_log(11, 128'h0000020C_0000020D_0000020E_0000020F, 1'b0, 1'b1);
      chk("frame_cnt_t3", 128'(frame_cnt), 128'd3);

      // Early TLAST on pixel 5 of line 0
      for (int p = 0; p < 6; p++)
         send_beat(32'h300 + 32'(p), (p == 0), (p == 5), st);
      for (int p = 0; p < H; p++)
         send_beat(32'h308 + 32'(p), 1'b0, (p == H - 1), st);
      drain();
      chk_log(12, 128'h00000300_00000301_00000302_00000303, 1'b1, 1'b0);
      chk_log(13, 128'h00000304_00000305_00000000_00000000, 1'b0, 1'b1);
      chk_log(15, 128'h0000030C_0000030D_0000030E_0000030F, 1'b0, 1'b1);
      chk("err_len_set", 128'(err_len), 128'd1);
      chk("frame_cnt_t4", 128'(frame_cnt), 128'd4);
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      @(negedge clk);
      chk("err_len_clr", 128'(err_len), 128'd0);
      @(posedge clk);
      #1;

      // USER mid-line at pixel 2 restarts the frame
      send_beat(32'h400, 1'b1, 1'b0, st);
      send_beat(32'h401, 1'b0, 1'b0, st);
      send_beat(32'h402, 1'b1, 1'b0, st);
      repeat (2) @(posedge clk);
      #1;
      chk("restart_frame_cnt", 128'(frame_cnt), 128'd4);
      chk("restart_err_len", 128'(err_len), 128'd1);
      for (int p = 1; p < H; p++)
         send_beat(32'h402 + 32'(p), 1'b0, (p == H - 1), st);
      for (int p = 0; p < H; p++)
         send_beat(32'h410 + 32'(p), 1'b0, (p == H - 1), st);
      drain();
      chk_log(16, 128'h00000400_00000401_00000000_00000000, 1'b1, 1'b1);
      chk_log(17, 128'h00000402_00000403_00000404_00000405, 1'b1, 1'b0);
      chk_log(18, 128'h00000406_00000407_00000408_00000409, 1'b0, 1'b1);
      chk("frame_cnt_t5", 128'(frame_cnt), 128'd5);

      // Reset while a word is pending
      fwr_rdy = 1'b0;
      for (int p = 0; p < 4; p++)
         send_beat(32'h500 + 32'(p), (p == 0), 1'b0, st);
      @(negedge clk);
      chk("rst_pending_vld", 128'(fwr_vld), 128'd1);
      @(posedge clk);
      #1;
      S_AXIS_ARESETN = 1'b0;
      @(posedge clk);
      #1;
      S_AXIS_ARESETN = 1'b1;
      fwr_rdy = 1'b1;
      @(negedge clk);
      chk("rst_fwr_vld", 128'(fwr_vld), 128'd0);
      chk("rst_tready", 128'(S_AXIS_TREADY), 128'd0);
      chk("rst_frame_cnt", 128'(frame_cnt), 128'd0);
      chk("rst_err_len", 128'(err_len), 128'd0);
      @(posedge clk);
      #1;
      send_frame(32'h600);
      drain();
      chk_log(21, 128'h00000600_00000601_00000602_00000603, 1'b1, 1'b0);
      chk_log(24, 128'h0000060C_0000060D_0000060E_0000060F, 1'b0, 1'b1);
      chk("frame_cnt_t6", 128'(frame_cnt), 128'd1);

      drain();
      chk("expected_queue_empty", 128'(exp_q.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
